miniled_serial_rx: RTL and testbench

//  Panel-side receiver for the MiniLED driver's serial output: oversamples DCLK/SDI/LE on I_clk.

---
 rtl/miniled_serial_rx.sv | 168 ++++++++++++++++
 tb/tb_miniled_serial_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/miniled_serial_rx.sv
// rtl/miniled_serial_rx.sv - oversampling receiver for the MiniLED driver's DCLK/SDI/LE serial output
// Optional row-scan decode is built when MINILED_RX_SCAN_DECODE_EN is defined.
module miniled_serial_rx #(
  parameter int WORD_BITS     = 16,
  parameter int NUM_LEDS      = 384,
  parameter int VSYNC_LE_CLKS = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 DCLK,
  input  logic                 SDI,
  input  logic                 LE,
  input  logic                 scan1,
  input  logic                 scan2,
  input  logic                 scan3,
  input  logic                 scan4,
  output logic [WORD_BITS-1:0] rx_data,
  output logic [8:0]           rx_index,
  output logic                 rx_valid,
  output logic                 rx_frame,
  output logic                 len_err,
  output logic                 ovf_err,
  output logic [1:0]           rx_scan,
  output logic                 scan_err
);

  localparam logic [4:0] WORD_CNT = 5'(WORD_BITS);
  localparam logic [8:0] LAST_IDX = 9'(NUM_LEDS - 1);

  logic [SYNC_STAGES-1:0] dclk_sync, sdi_sync, le_sync;
  logic                   dclk_d, le_d;
  logic                   dclk_s, sdi_s, le_s;
  logic                   dclk_rise, le_rise, le_fall;

  logic [WORD_BITS-1:0] shift, shift_n;
  logic [4:0]           bit_cnt, bit_cnt_n;
  logic [2:0]           le_clks, le_clks_n;
  logic [8:0]           idx;
  logic                 win_open;
  logic                 do_data, do_frame;

  assign dclk_s    = dclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign le_s      = le_sync[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~dclk_d;
  assign le_rise   = le_s & ~le_d;
  assign le_fall   = ~le_s & le_d;

  // LE chain resets high so an LE already high at reset release never looks like a rise.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      dclk_sync <= '0;
      sdi_sync  <= '0;
      le_sync   <= '1;
      dclk_d    <= 1'b0;
      le_d      <= 1'b1;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], DCLK};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      le_sync   <= {le_sync[SYNC_STAGES-2:0], LE};
      dclk_d    <= dclk_s;
      le_d      <= le_s;
    end
  end

  // A DCLK edge coinciding with the LE fall is folded in before classification.
  always_comb begin
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    le_clks_n = le_clks;
    if (dclk_rise) begin
      shift_n = {shift[WORD_BITS-2:0], sdi_s};
      if (bit_cnt != 5'd31) bit_cnt_n = bit_cnt + 5'd1;
      if (le_d && le_clks != 3'd7) le_clks_n = le_clks + 3'd1;
    end
    if (le_rise) le_clks_n = 3'd0;
    do_data  = le_fall && win_open && (le_clks_n == 3'd1);
    do_frame = le_fall && win_open && (int'(le_clks_n) >= VSYNC_LE_CLKS);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      shift    <= '0;
      bit_cnt  <= '0;
      le_clks  <= '0;
      idx      <= '0;
      win_open <= 1'b0;
      rx_data  <= '0;
      rx_index <= '0;
      rx_valid <= 1'b0;
      rx_frame <= 1'b0;
      len_err  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_frame <= 1'b0;
      len_err  <= 1'b0;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      le_clks  <= le_clks_n;
      if (le_rise) win_open <= 1'b1;
      if (le_fall) begin
        win_open <= 1'b0;
        bit_cnt  <= '0;
        le_clks  <= '0;
      end
      if (do_data) begin
        rx_data  <= shift_n;
        rx_index <= idx;
        rx_valid <= 1'b1;
        len_err  <= (bit_cnt_n != WORD_CNT);
        if (idx == LAST_IDX) begin
          idx     <= '0;
          ovf_err <= 1'b1;
        end else begin
          idx <= idx + 9'd1;
        end
      end
      if (do_frame) begin
        rx_frame <= 1'b1;
        idx      <= '0;
        ovf_err  <= 1'b0;
      end
    end
  end

`ifdef MINILED_RX_SCAN_DECODE_EN
  logic [3:0] scan_pipe [SYNC_STAGES];
  logic [3:0] scan_s, scan_prev;
  logic [1:0] scan_code;
  logic       scan_onehot;

  assign scan_s      = scan_pipe[SYNC_STAGES-1];
  assign scan_onehot = (scan_s != 4'd0) && ((scan_s & (scan_s - 4'd1)) == 4'd0);

  always_comb begin
    scan_code = 2'd0;
    case (scan_s)
      4'b0010: scan_code = 2'd1;
      4'b0100: scan_code = 2'd2;
      4'b1000: scan_code = 2'd3;
      default: scan_code = 2'd0;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) scan_pipe[i] <= '0;
      scan_prev <= '0;
      rx_scan   <= '0;
      scan_err  <= 1'b0;
    end else begin
      scan_pipe[0] <= {scan4, scan3, scan2, scan1};
      for (int i = 1; i < SYNC_STAGES; i++) scan_pipe[i] <= scan_pipe[i-1];
      scan_prev <= scan_s;
      if (scan_onehot) rx_scan <= scan_code;
      scan_err <= (scan_s != scan_prev) && !scan_onehot;
    end
  end
`else
  logic unused_scan;
  assign unused_scan = ^{scan1, scan2, scan3, scan4};
  assign rx_scan     = 2'd0;
  assign scan_err    = 1'b0;
`endif

endmodule

// File: tb/tb_miniled_serial_rx.sv
// tb/tb_miniled_serial_rx.sv - directed vector bench for miniled_serial_rx
module tb_miniled_serial_rx;
  logic I_clk = 1'b0;
  logic I_rst_n = 1'b0;
  logic DCLK = 1'b0, SDI = 1'b0, LE = 1'b0;
  logic scan1 = 1'b0, scan2 = 1'b0, scan3 = 1'b0, scan4 = 1'b0;
  logic [15:0] rx_data;
  logic [8:0]  rx_index;
  logic        rx_valid, rx_frame, len_err, ovf_err, scan_err;
  logic [1:0]  rx_scan;

  always #10 I_clk = ~I_clk;

  miniled_serial_rx dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .DCLK(DCLK), .SDI(SDI), .LE(LE),
    .scan1(scan1), .scan2(scan2), .scan3(scan3), .scan4(scan4),
    .rx_data(rx_data), .rx_index(rx_index), .rx_valid(rx_valid), .rx_frame(rx_frame),
    .len_err(len_err), .ovf_err(ovf_err), .rx_scan(rx_scan), .scan_err(scan_err)
  );

  int n_vec = 0, n_miss = 0;
  int valid_cnt = 0, frame_cnt = 0, len_cnt = 0, serr_cnt = 0, scan_nz = 0;
  logic [15:0] last_data = '0;
  logic [8:0]  last_index = '0;

  always @(negedge I_clk) begin
    if (rx_valid) begin
      valid_cnt  <= valid_cnt + 1;
      last_data  <= rx_data;
      last_index <= rx_index;
    end
    if (rx_frame) frame_cnt <= frame_cnt + 1;
    if (len_err)  len_cnt   <= len_cnt + 1;
    if (scan_err) serr_cnt  <= serr_cnt + 1;
    if (rx_scan != 2'd0) scan_nz <= scan_nz + 1;
  end

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          le_edges;
    int          exp_valid;
    int          exp_frame;
    int          exp_len;
    logic [15:0] exp_data;
    logic [8:0]  exp_index;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    SDI = b;
    #40 DCLK = 1'b1;
    #40 DCLK = 1'b0;
  endtask

  // nbits DCLK edges of w (MSB first); LE goes high before the last le_edges of them
  task automatic send_word(input logic [31:0] w, input int nbits, input int le_edges);
    for (int i = 0; i < nbits; i++) begin
      if (i == nbits - le_edges) LE = 1'b1;
      send_bit(w[nbits-1-i]);
    end
    #40 LE = 1'b0;
    #200;
  endtask

  initial begin
    int v0, f0, l0, s0;
    vecs[0] = '{32'h0000A5C3, 16, 1, 1, 0, 0, 16'hA5C3, 9'd0};
    vecs[1] = '{32'h00001234, 16, 1, 1, 0, 0, 16'h1234, 9'd1};
    vecs[2] = '{32'h00000000,  3, 3, 0, 1, 0, 16'h0000, 9'd0};
    vecs[3] = '{32'h0000BEEF, 16, 1, 1, 0, 0, 16'hBEEF, 9'd0};
    vecs[4] = '{32'h00000ABC, 12, 1, 1, 0, 1, 16'hFABC, 9'd1};
    vecs[5] = '{32'h00000003, 16, 2, 0, 0, 0, 16'h0000, 9'd0};
    vecs[6] = '{32'h00005A5A, 16, 1, 1, 0, 0, 16'h5A5A, 9'd2};
    vecs[7] = '{32'h00012345, 17, 1, 1, 0, 1, 16'h2345, 9'd3};

    #103;
    check("reset_outputs", {rx_data, rx_index, rx_valid, rx_frame, len_err, ovf_err, rx_scan, scan_err}, 32'd0);
    I_rst_n = 1'b1;
    #100;

    for (int v = 0; v < 8; v++) begin
      v0 = valid_cnt; f0 = frame_cnt; l0 = len_cnt;
      send_word(vecs[v].word, vecs[v].nbits, vecs[v].le_edges);
      check($sformatf("vec%0d_valid", v), valid_cnt - v0, vecs[v].exp_valid);
      check($sformatf("vec%0d_frame", v), frame_cnt - f0, vecs[v].exp_frame);
      check($sformatf("vec%0d_len", v), len_cnt - l0, vecs[v].exp_len);
      if (vecs[v].exp_valid != 0) begin
        check($sformatf("vec%0d_data", v), last_data, vecs[v].exp_data);
        check($sformatf("vec%0d_index", v), last_index, vecs[v].exp_index);
        check($sformatf("vec%0d_hold", v), rx_data, vecs[v].exp_data);
      end
    end
    check("ovf_after_table", ovf_err, 1'b0);

    // index wrap over a full frame of single-edge latches
    send_word(32'd0, 3, 3);
    for (int i = 0; i < 385; i++) begin
      send_word(i, 1, 1);
      if (i == 382) begin
        check("wrap_idx382", last_index, 9'd382);
        check("wrap_ovf382", ovf_err, 1'b0);
      end
      if (i == 383) begin
        check("wrap_idx383", last_index, 9'd383);
        check("wrap_ovf383", ovf_err, 1'b1);
      end
      if (i == 384) begin
        check("wrap_idx384", last_index, 9'd0);
        check("wrap_ovf384", ovf_err, 1'b1);
      end
    end
    f0 = frame_cnt;
    send_word(32'd0, 4, 4);
    check("ovf_frame_pulse", frame_cnt - f0, 1);
    check("ovf_cleared", ovf_err, 1'b0);

    // one word to move idx off zero, then reset mid-word
    send_word(32'h00001111, 16, 1);
    v0 = valid_cnt; f0 = frame_cnt; l0 = len_cnt;
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    #30 I_rst_n = 1'b0;
    #200;
    check("rst_no_pulse", (valid_cnt - v0) + (frame_cnt - f0) + (len_cnt - l0), 0);
    check("rst_data_zero", {rx_data, rx_index, ovf_err}, 26'd0);
    LE = 1'b1;
    #100 I_rst_n = 1'b1;
    #100;
    send_bit(1'b1);
    #40 LE = 1'b0;
    #200;
    check("le_high_at_release", (valid_cnt - v0) + (frame_cnt - f0) + (len_cnt - l0), 0);
    send_word(32'h0000C0DE, 16, 1);
    check("post_rst_valid", valid_cnt - v0, 1);
    check("post_rst_data", last_data, 16'hC0DE);
    check("post_rst_index", last_index, 9'd0);
    check("post_rst_len", len_cnt - l0, 0);

    s0 = serr_cnt;
    scan3 = 1'b1;
    #200;
`ifdef MINILED_RX_SCAN_DECODE_EN
    check("scan3_code", rx_scan, 2'd2);
    check("scan3_no_err", serr_cnt - s0, 0);
`endif
    scan3 = 1'b0; scan1 = 1'b1; scan2 = 1'b1;
    #200;
`ifdef MINILED_RX_SCAN_DECODE_EN
    check("multihot_err", serr_cnt - s0, 1);
    check("multihot_hold", rx_scan, 2'd2);
`else
    check("scan_disabled_code", scan_nz, 0);
    check("scan_disabled_err", serr_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
